// File: rtl/descramble_lc.sv
// descramble_lc: receive-side 802.11a descrambler.
// Rebuilds the x^7+x^4+1 scrambler state from the first seven SERVICE bits.
// These bits are zero before scrambling, so the received bits are the
// scrambler output itself. The block then descrambles the rest of the packet,
// flags non-zero reserved SERVICE bits, and packs PSDU bits into bytes with
// the earliest bit in bit 0. SERVICE, tail and pad bits are dropped.
//
// Handshake: input bits are qualified by data_bit_valid alone. There is no
// ready and no backpressure: every valid bit is consumed on the rising edge
// where it is presented. data_bit_sop means something only together with
// data_bit_valid. Every output strobe is a registered single-cycle pulse with
// no ready, and the data outputs hold their value between strobes.
module descramble_lc #(
    parameter int SEED_LENGTH    = 7,
    parameter int SERVICE_LENGTH = 16,
    parameter int BIT_CNT_WIDTH  = 20
) (
    input  logic        clk_Modulation,
    input  logic        reset,
    input  logic [15:0] packetlength,
    input  logic        data_bit_sop,
    input  logic        data_bit_valid,
    input  logic        data_bit,
    output logic [6:0]  seed,
    output logic        seed_valid,
    output logic        service_err,
    output logic        descramble_byte_valid,
    output logic [7:0]  descramble_byte,
    output logic        descramble_byte_last,
    output logic        packet_done,
    output logic        packet_abort
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SEED    = 3'd1,
        SERVICE = 3'd2,
        PSDU    = 3'd3,
        DISCARD = 3'd4
    } state_t;

    localparam logic [BIT_CNT_WIDTH-1:0] SEED_LAST = BIT_CNT_WIDTH'(SEED_LENGTH - 1);
    localparam logic [BIT_CNT_WIDTH-1:0] SVC_LAST  = BIT_CNT_WIDTH'(SERVICE_LENGTH - 1);
    localparam logic [BIT_CNT_WIDTH-1:0] SVC_LEN   = BIT_CNT_WIDTH'(SERVICE_LENGTH);
    // PSDU bit position inside its byte is (bit_cnt - SERVICE_LENGTH) mod 8.
    localparam logic [2:0] SVC_PHASE = 3'(SERVICE_LENGTH % 8);

    state_t                   state;
    logic [6:0]               h;          // local copy of the scrambler register
    logic [BIT_CNT_WIDTH-1:0] bit_cnt;    // bits of this packet consumed so far
    logic [BIT_CNT_WIDTH-1:0] psdu_end;   // first bit index after the PSDU
    logic                     zero_len;   // packet carries no PSDU bytes
    logic [7:0]               byte_acc;   // partial PSDU byte

    logic                     fb;
    logic                     dout;
    logic                     start;
    logic                     in_packet;
    logic [2:0]               byte_pos;
    logic [BIT_CNT_WIDTH-1:0] end_next;
    logic [BIT_CNT_WIDTH-1:0] bit_cnt_inc;
    logic [BIT_CNT_WIDTH-1:0] psdu_last;

    assign fb          = h[6] ^ h[3];
    assign dout        = data_bit ^ fb;
    assign start       = data_bit_valid & data_bit_sop;
    assign in_packet   = (state == SEED) || (state == SERVICE) || (state == PSDU);
    assign byte_pos    = bit_cnt[2:0] - SVC_PHASE;
    assign end_next    = SVC_LEN + BIT_CNT_WIDTH'({packetlength, 3'b000});
    assign bit_cnt_inc = bit_cnt + BIT_CNT_WIDTH'(1);
    assign psdu_last   = psdu_end - BIT_CNT_WIDTH'(1);

    // Packet FSM, bit processing and all registered outputs.
    always_ff @(posedge clk_Modulation or posedge reset) begin
        if (reset) begin
            state                 <= IDLE;
            h                     <= '0;
            bit_cnt               <= '0;
            psdu_end              <= '0;
            zero_len              <= 1'b0;
            byte_acc              <= '0;
            seed                  <= '0;
            seed_valid            <= 1'b0;
            service_err           <= 1'b0;
            descramble_byte_valid <= 1'b0;
            descramble_byte       <= '0;
            descramble_byte_last  <= 1'b0;
            packet_done           <= 1'b0;
            packet_abort          <= 1'b0;
        end else begin
            seed_valid            <= 1'b0;
            descramble_byte_valid <= 1'b0;
            descramble_byte_last  <= 1'b0;
            packet_done           <= 1'b0;
            packet_abort          <= 1'b0;
            if (start) begin
                // A sop starts a new packet from any state. Inside a packet it
                // also aborts that packet and drops its partial byte.
                packet_abort <= in_packet;
                psdu_end     <= end_next;
                zero_len     <= (packetlength == 16'd0);
                service_err  <= 1'b0;
                h            <= {h[5:0], data_bit};
                bit_cnt      <= BIT_CNT_WIDTH'(1);
                byte_acc     <= '0;
                state        <= SEED;
            end else if (data_bit_valid) begin
                case (state)
                    SEED: begin
                        h       <= {h[5:0], data_bit};
                        bit_cnt <= bit_cnt_inc;
                        if (bit_cnt == SEED_LAST) begin
                            seed       <= {h[5:0], data_bit};
                            seed_valid <= 1'b1;
                            state      <= SERVICE;
                        end
                    end
                    SERVICE: begin
                        h       <= {h[5:0], fb};
                        bit_cnt <= bit_cnt_inc;
                        if (dout) service_err <= 1'b1;
                        if (bit_cnt == SVC_LAST) begin
                            if (zero_len) begin
                                packet_done <= 1'b1;
                                state       <= DISCARD;
                            end else begin
                                state <= PSDU;
                            end
                        end
                    end
                    PSDU: begin
                        h                  <= {h[5:0], fb};
                        bit_cnt            <= bit_cnt_inc;
                        byte_acc[byte_pos] <= dout;
                        if (byte_pos == 3'd7) begin
                            descramble_byte       <= {dout, byte_acc[6:0]};
                            descramble_byte_valid <= 1'b1;
                        end
                        if (bit_cnt == psdu_last) begin
                            descramble_byte_last <= 1'b1;
                            packet_done          <= 1'b1;
                            state                <= DISCARD;
                        end
                    end
                    default: begin
                        // IDLE and DISCARD drop bits until the next sop.
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/descramble_lc.md
Name: descramble_lc

Overview:
- RX-side 802.11a descrambler; sits between the Viterbi decoder output and the PSDU byte sink.
- Recovers the scrambler state from the first 7 SERVICE bits, which are zero before scrambling, then descrambles the rest of the packet.
- Checks that reserved SERVICE bits are zero, strips SERVICE/tail/pad, and packs PSDU bits into bytes, LSB first.

Parameters:
SEED_LENGTH, 7, number of leading SERVICE bits used for state recovery
SERVICE_LENGTH, 16, SERVICE field length in bits
BIT_CNT_WIDTH, 20, width of per-packet bit counter

Ports:
clk_Modulation  input  1  system clock, all logic rising-edge
reset  input  1  asynchronous, active-high reset
packetlength  input  16  PSDU length in bytes (from SIGNAL decode), sampled on data_bit_sop
data_bit_sop  input  1  qualifies the first SERVICE bit of a packet; valid only with data_bit_valid
data_bit_valid  input  1  input bit strobe; gaps allowed
data_bit  input  1  scrambled decoded bit
seed  output  7  recovered scrambler register, bit6 = first received bit
seed_valid  output  1  one-cycle pulse when seed is updated
service_err  output  1  reserved SERVICE bits 7..15 not all zero after descrambling; held until next sop
descramble_byte_valid  output  1  one-cycle strobe per PSDU byte
descramble_byte  output  8  PSDU byte, bit0 = earliest bit
descramble_byte_last  output  1  coincident with valid on final PSDU byte
packet_done  output  1  one-cycle pulse at end of PSDU
packet_abort  output  1  one-cycle pulse when sop arrives while a packet is in progress

Behaviour:
- Reset (async): all outputs 0, seed = 0, FSM = IDLE, counters and shift register cleared.
- FSM states: IDLE, SEED, SERVICE, PSDU, DISCARD. Only cycles with data_bit_valid=1 advance bit processing.
- IDLE:
  - data_bit_valid & data_bit_sop latches packetlength and computes psdu_end = SERVICE_LENGTH + 8*packetlength, zero-extended to BIT_CNT_WIDTH.
  - Clears service_err and bit counter, and consumes the sop bit as bit 0 → SEED.
  - Valid bits without sop are ignored.
- SEED (bits 0..6): shift-in register h <= {h[5:0], data_bit}; no descrambled output.
  - After bit 6 is consumed, the next cycle drives seed = h and pulses seed_valid → SERVICE.
- SERVICE (bits 7..15) and PSDU, per valid bit:
  - fb = h[6]^h[3]; out = data_bit^fb; h <= {h[5:0], fb}.
  - SERVICE: any out=1 sets service_err. After bit 15:
    - packetlength==0 → pulse packet_done next cycle, go to DISCARD;
    - otherwise → PSDU.
  - service_err does not stop processing.
- PSDU:
  - out is shifted into a byte accumulator at position (bit_cnt-16)%8.
  - When the 8th bit of a byte is consumed, the next cycle drives descramble_byte and pulses descramble_byte_valid (latency 1 cycle from last bit).
  - On bit psdu_end-1 the byte strobe also carries descramble_byte_last=1 and packet_done=1 in the same cycle; go to DISCARD.
- DISCARD: tail and pad bits are consumed without output. FSM stays here until the next sop.
- A sop in DISCARD starts a new packet exactly as in IDLE, with no abort.
- A sop in SEED, SERVICE or PSDU:
  - pulse packet_abort;
  - drop the partial byte;
  - restart in SEED with that bit as bit 0, using newly sampled packetlength;
  - emit no packet_done for the aborted packet.
- data_bit_sop without data_bit_valid is ignored.
- descramble_byte holds its last value between strobes.
- seed holds until the next seed_valid.
- Bit counter is BIT_CNT_WIDTH bits; max psdu_end = 16 + 8*65535 = 524296 fits without wrap. packetlength values above 4095 are processed as given.
- Reset asserted mid-packet: immediate return to IDLE with all outputs 0; no done or abort pulse.

Test Plan:
- Nominal packet: TX scrambler model seeded 7'b0001111; inject SERVICE=16'h0000, packetlength=2, PSDU 8'hA5, 8'h3C, 6 tail, 2 pad, continuous valid.
  → seed=7'h70 with seed_valid once; bytes 8'hA5 then 8'h3C; last and done on the second byte; service_err=0; no output for tail/pad.
- Same packet with data_bit_valid toggled 1-0-0-1 randomly → identical bytes and seed; each byte strobe exactly one cycle after its 8th valid bit.
- SERVICE reserved bit 9 set before scrambling → service_err=1 from bit 9 until next sop; PSDU bytes still correct.
- packetlength=0 → seed_valid, then packet_done one cycle after bit 15; zero byte strobes, no descramble_byte_last.
- sop asserted at PSDU bit 20 of a 4-byte packet, new packetlength=1 with data 8'hFF → packet_abort pulse; old partial byte never output; new packet yields 8'hFF with last and done.
- Back-to-back packets, second sop on the first bit after the first packet's pad (in DISCARD) → no abort; both packets decode correctly.
- Async reset mid-PSDU → all outputs 0 immediately; the next packet decodes correctly.
